// File: rtl/boron_pkg.sv
// Shared definitions for the BORON round engine: block geometry, the 4-bit
// S-box table, the engine FSM encoding and the round-key index width helper.
package boron_pkg;

  localparam int unsigned BLOCK_W = 64;
  localparam int unsigned NIBBLES = 16;

  // S-box table, entry n in bits [4n+3:4n]: E 4 B 1 7 9 C A D 2 0 F 8 5 3 6
  localparam logic [63:0] SBOX_TABLE = 64'h6358_F02D_AC97_1B4E;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Width needed to index round keys 0..rounds (rounds itself is the whitening key)
  function automatic int unsigned rk_idx_w(input int unsigned rounds);
    return $clog2(rounds + 1);
  endfunction

endpackage

// File: rtl/boron_round.sv
// One combinational BORON round: key add, 16 parallel S-boxes, permutation.
// Ports: i_state   - current 64-bit state
//        i_rk      - 64-bit round key
//        o_state_c - next state (combinational)
module boron_round
  import boron_pkg::*;
(
  input  logic [BLOCK_W-1:0] i_state,
  input  logic [BLOCK_W-1:0] i_rk,
  output logic [BLOCK_W-1:0] o_state_c
);

  logic [BLOCK_W-1:0] w_mix;
  logic [BLOCK_W-1:0] w_sub;

  assign w_mix = i_state ^ i_rk;

  for (genvar n = 0; n < NIBBLES; n++) begin : g_sbox
    s_box u_s_box (
      .i_nib   (w_mix[4*n +: 4]),
      .o_nib_c (w_sub[4*n +: 4])
    );
  end

  permutation_layer u_perm (
    .i_x   (w_sub),
    .o_y_c (o_state_c)
  );

endmodule

// File: rtl/permutation_layer.sv
// BORON 64-bit permutation layer: each 16-bit word is rotated left by
// 1/4/7/9 (word 0..3), then the words are mixed with an invertible XOR network.
// Ports: i_x   - 64-bit substituted state
//        o_y_c - permuted state (combinational)
module permutation_layer
  import boron_pkg::*;
(
  input  logic [BLOCK_W-1:0] i_x,
  output logic [BLOCK_W-1:0] o_y_c
);

  logic [15:0] w_r0;
  logic [15:0] w_r1;
  logic [15:0] w_r2;
  logic [15:0] w_r3;

  assign w_r0 = {i_x[14:0],  i_x[15]};
  assign w_r1 = {i_x[27:16], i_x[31:28]};
  assign w_r2 = {i_x[40:32], i_x[47:41]};
  assign w_r3 = {i_x[54:48], i_x[63:55]};

  // Word 3 folds in words 0 and 1 so the network stays invertible
  assign o_y_c = {w_r3 ^ w_r0 ^ w_r1, w_r2 ^ w_r3, w_r1 ^ w_r2, w_r0 ^ w_r1};

endmodule

// File: rtl/s_box.sv
// 4-bit BORON S-box lookup.
// Ports: i_nib  - input nibble
//        o_nib_c - substituted nibble (combinational)
module s_box
  import boron_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib_c
);

  assign o_nib_c = SBOX_TABLE[{i_nib, 2'b00} +: 4];

endmodule

// File: rtl/boron_round_engine.sv
// Iterative BORON encryption engine: ROUNDS keyed rounds computed UNROLL per
// clock, followed by a final whitening key add. Round keys come from an
// external store addressed by o_rk_idx and must return in the same cycle.
// Optional macro BORON_ABORT_EN adds i_abort to cancel a block in RUN/FINAL.
// Ports: i_clk, i_rst (sync, active-high)
//        i_valid/o_ready/i_msg      - plaintext handshake (accept only in IDLE)
//        o_rk_idx/i_rk              - round-key index out, UNROLL key lanes in
//        o_valid/i_ready/o_cipher   - ciphertext handshake (held in DONE)
//        o_busy                     - high in RUN or FINAL
//        i_abort                    - only with BORON_ABORT_EN
module boron_round_engine
  import boron_pkg::*;
#(
  parameter int unsigned ROUNDS = 25,
  parameter int unsigned UNROLL = 1,
  parameter int unsigned IDX_W  = rk_idx_w(ROUNDS)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [BLOCK_W-1:0]        i_msg,
  output logic [IDX_W-1:0]          o_rk_idx,
  input  logic [BLOCK_W*UNROLL-1:0] i_rk,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [BLOCK_W-1:0]        o_cipher,
  output logic                      o_busy
`ifdef BORON_ABORT_EN
  ,
  input  logic                      i_abort
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS);
  localparam logic [IDX_W-1:0] STEP     = IDX_W'(UNROLL);

  if ((UNROLL == 0) || ((ROUNDS % UNROLL) != 0)) begin : g_bad_unroll
    $error("boron_round_engine: ROUNDS must be a non-zero multiple of UNROLL");
  end
  if ((ROUNDS >> IDX_W) != 0) begin : g_bad_idx_w
    $error("boron_round_engine: IDX_W too narrow to hold ROUNDS");
  end

  state_e               r_state;
  state_e               w_state_nxt;
  logic [BLOCK_W-1:0]   r_x;
  logic [BLOCK_W-1:0]   w_x_nxt;
  logic [IDX_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     w_cnt_nxt;
  logic [IDX_W-1:0]     w_cnt_step;
  logic [IDX_W-1:0]     w_rk_idx_nxt;
  logic [BLOCK_W-1:0]   w_cipher_nxt;

  logic                 r_ready;
  logic                 r_valid;
  logic                 r_busy;
  logic [IDX_W-1:0]     r_rk_idx;
  logic [BLOCK_W-1:0]   r_cipher;

  // Unrolled round chain: lane j of i_rk feeds round j of this clock
  logic [UNROLL:0][BLOCK_W-1:0] w_chain;

  assign w_chain[0] = r_x;

  for (genvar j = 0; j < UNROLL; j++) begin : g_round
    boron_round u_round (
      .i_state   (w_chain[j]),
      .i_rk      (i_rk[BLOCK_W*j +: BLOCK_W]),
      .o_state_c (w_chain[j+1])
    );
  end

  assign w_cnt_step = r_cnt + STEP;

  // Next-state, datapath and next-output decode
  always_comb begin
    w_state_nxt  = r_state;
    w_x_nxt      = r_x;
    w_cnt_nxt    = r_cnt;
    w_rk_idx_nxt = '0;
    w_cipher_nxt = '0;

    case (r_state)
      IDLE: begin
        if (i_valid) begin
          w_x_nxt     = i_msg;
          w_cnt_nxt   = '0;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_x_nxt   = w_chain[UNROLL];
        w_cnt_nxt = w_cnt_step;
        if (w_cnt_step == LAST_IDX) begin
          w_state_nxt = FINAL;
        end
      end
      FINAL: begin
        w_x_nxt     = r_x ^ i_rk[BLOCK_W-1:0];
        w_state_nxt = DONE;
      end
      DONE: begin
        if (i_ready) begin
          w_state_nxt = IDLE;
        end
      end
    endcase

`ifdef BORON_ABORT_EN
    if (i_abort && ((r_state == RUN) || (r_state == FINAL))) begin
      w_state_nxt = IDLE;
      w_x_nxt     = '0;
      w_cnt_nxt   = '0;
    end
`endif

    // Outputs are registered, so decode them from the upcoming state
    case (w_state_nxt)
      RUN:     w_rk_idx_nxt = w_cnt_nxt;
      FINAL:   w_rk_idx_nxt = LAST_IDX;
      default: w_rk_idx_nxt = '0;
    endcase
    if (w_state_nxt == DONE) begin
      w_cipher_nxt = w_x_nxt;
    end
  end

  // State, datapath and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_x      <= '0;
      r_cnt    <= '0;
      r_ready  <= 1'b1;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_rk_idx <= '0;
      r_cipher <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_x      <= w_x_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ready  <= (w_state_nxt == IDLE);
      r_valid  <= (w_state_nxt == DONE);
      r_busy   <= (w_state_nxt == RUN) || (w_state_nxt == FINAL);
      r_rk_idx <= w_rk_idx_nxt;
      r_cipher <= w_cipher_nxt;
    end
  end

  assign o_ready  = r_ready;
  assign o_valid  = r_valid;
  assign o_busy   = r_busy;
  assign o_rk_idx = r_rk_idx;
  assign o_cipher = r_cipher;

endmodule

// File: tb/tb_boron_round_engine.sv
// Scoreboard bench: three engines (UNROLL 1, 5, 25) share plaintext stimulus;
// each has its own key store, ciphertext queue and monitor.
module tb_boron_round_engine;

  localparam int unsigned ROUNDS = 25;
  localparam int unsigned IDX_W  = 5;

  typedef struct {
    logic [63:0] ct;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [63:0] msg;
  logic [2:0]  rdy_in;
`ifdef BORON_ABORT_EN
  logic        abort;
`endif

  logic [2:0]       ready_o;
  logic [2:0]       valid_o;
  logic [2:0]       busy_o;
  logic [63:0]      cipher_o [3];
  logic [IDX_W-1:0] idx_o    [3];

  exp_t q [3][$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [3:0] TB_SBOX [16] = '{4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
                                          4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6};
  localparam int TB_ROT [4] = '{1, 4, 7, 9};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] rk(input int n);
    return 64'h0F0F_0F0F_0F0F_0F0F ^ 64'(n);
  endfunction

  function automatic logic [15:0] rotl16(input logic [15:0] w, input int s);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[(i + s) % 16] = w[i];
    return r;
  endfunction

  function automatic logic [63:0] ref_enc(input logic [63:0] m);
    logic [63:0] x;
    logic [15:0] r [4];
    x = m;
    for (int rnd = 0; rnd < int'(ROUNDS); rnd++) begin
      x = x ^ rk(rnd);
      for (int n = 0; n < 16; n++) x[4*n +: 4] = TB_SBOX[x[4*n +: 4]];
      for (int w = 0; w < 4; w++) r[w] = rotl16(x[16*w +: 16], TB_ROT[w]);
      x[15:0]  = r[0] ^ r[1];
      x[31:16] = r[1] ^ r[2];
      x[47:32] = r[2] ^ r[3];
      x[63:48] = r[3] ^ r[0] ^ r[1];
    end
    return x ^ rk(int'(ROUNDS));
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int unsigned U   = (g == 0) ? 1 : (g == 1) ? 5 : 25;
    localparam int          LAT = (g == 0) ? 27 : (g == 1) ? 7 : 3;

    logic [64*U-1:0] rk_bus;
    logic            prev_v;
    int              exp_idx;

    // Combinational key store: lane j returns rk[idx+j]
    always_comb begin
      rk_bus = '0;
      for (int j = 0; j < int'(U); j++) rk_bus[64*j +: 64] = rk(int'(idx_o[g]) + j);
    end

    boron_round_engine #(.ROUNDS(ROUNDS), .UNROLL(U)) u_dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_valid  (valid),
      .o_ready  (ready_o[g]),
      .i_msg    (msg),
      .o_rk_idx (idx_o[g]),
      .i_rk     (rk_bus),
      .o_valid  (valid_o[g]),
      .i_ready  (rdy_in[g]),
      .o_cipher (cipher_o[g]),
      .o_busy   (busy_o[g])
`ifdef BORON_ABORT_EN
      ,
      .i_abort  (abort)
`endif
    );

    // Monitor: key index sequence, latency and ciphertext against the queue
    initial begin
      prev_v  = 1'b0;
      exp_idx = 0;
      forever begin
        @(negedge clk);
        if (!rst) begin
          if (ready_o[g]) exp_idx = 0;
          if (busy_o[g]) begin
            check($sformatf("rk_idx_u%0d", U), 64'(idx_o[g]), 64'(exp_idx));
            exp_idx += int'(U);
          end
          if (valid_o[g] && !prev_v) begin
            if (q[g].size() == 0) begin
              check($sformatf("unexpected_valid_u%0d", U), 64'(valid_o[g]), 64'(0));
            end else begin
              check($sformatf("cipher_u%0d", U), cipher_o[g], q[g][0].ct);
              check($sformatf("latency_u%0d", U), 64'(cyc - q[g][0].acc + 1), 64'(LAT));
            end
          end
          if (valid_o[g] && rdy_in[g] && (q[g].size() > 0)) void'(q[g].pop_front());
        end
        prev_v = valid_o[g];
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((ready_o != 3'b111) && (n < 200)) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_idle", 64'(ready_o), 64'(3'b111));
  endtask

  task automatic send(input logic [63:0] m, input logic [2:0] mask);
    exp_t e;
    wait_idle();
    msg   = m;
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    e.ct  = ref_enc(m);
    e.acc = cyc;
    for (int g = 0; g < 3; g++) if (mask[g]) q[g].push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (((q[0].size() + q[1].size() + q[2].size()) != 0) && (n < 300)) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", 64'(q[0].size() + q[1].size() + q[2].size()), 64'(0));
  endtask

  task automatic wait_u1_idx(input int t);
    int n = 0;
    while (!(busy_o[0] && (idx_o[0] == IDX_W'(t))) && (n < 100)) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_u1_idx", 64'(idx_o[0]), 64'(t));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    valid  = 1'b0;
    msg    = '0;
    rdy_in = 3'b111;
`ifdef BORON_ABORT_EN
    abort  = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int g = 0; g < 3; g++) begin
      check("rst_ready",  64'(ready_o[g]), 64'(1));
      check("rst_valid",  64'(valid_o[g]), 64'(0));
      check("rst_cipher", cipher_o[g],     64'(0));
      check("rst_rk_idx", 64'(idx_o[g]),   64'(0));
      check("rst_busy",   64'(busy_o[g]),  64'(0));
    end

    // Known-answer vectors through all three unroll factors
    send(64'h0123_4567_89AB_CDEF, 3'b111);
    drain();
    send(64'hFEDC_BA98_7654_3210, 3'b111);
    drain();
    send(64'h0000_0000_0000_0000, 3'b111);
    drain();

    // Back-pressure on the UNROLL=1 engine
    rdy_in[0] = 1'b0;
    send(64'hDEAD_BEEF_CAFE_F00D, 3'b111);
    begin
      int n = 0;
      while (!valid_o[0] && (n < 100)) begin
        @(posedge clk); #1;
        n++;
      end
    end
    check("bp_valid_rise", 64'(valid_o[0]), 64'(1));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_valid_hold",  64'(valid_o[0]), 64'(1));
      check("bp_cipher_hold", cipher_o[0], ref_enc(64'hDEAD_BEEF_CAFE_F00D));
      check("bp_ready_low",   64'(ready_o[0]), 64'(0));
    end
    rdy_in[0] = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ready", 64'(ready_o[0]), 64'(1));
    check("bp_release_valid", 64'(valid_o[0]), 64'(0));
    send(64'h1111_2222_3333_4444, 3'b111);
    check("bp_next_accept", 64'(busy_o[0]), 64'(1));
    drain();

    // Reset during RUN on the UNROLL=1 engine; its block must vanish
    send(64'h5555_AAAA_5555_AAAA, 3'b110);
    wait_u1_idx(12);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst_ready",  64'(ready_o[0]), 64'(1));
    check("mrst_busy",   64'(busy_o[0]),  64'(0));
    check("mrst_valid",  64'(valid_o[0]), 64'(0));
    check("mrst_rk_idx", 64'(idx_o[0]),   64'(0));
    repeat (30) @(posedge clk);
    #1;
    send(64'h8000_0000_0000_0001, 3'b111);
    drain();

`ifdef BORON_ABORT_EN
    // Abort in FINAL on the UNROLL=1 engine
    send(64'h7777_0000_FFFF_1234, 3'b110);
    wait_u1_idx(25);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_ready",  64'(ready_o[0]), 64'(1));
    check("abort_busy",   64'(busy_o[0]),  64'(0));
    check("abort_cipher", cipher_o[0],     64'(0));
    repeat (30) @(posedge clk);
    #1;
    send(64'h0F1E_2D3C_4B5A_6978, 3'b111);
    drain();
`endif

    repeat (5) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) check("queue_empty", 64'(q[g].size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
